sram_responder: RTL and testbench



---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_array.sv | 26 ++
 rtl/sram_responder.sv | 112 +++++++++++
 tb/tb_sram_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types for the SRAM request interface: address/data words and the
// {valid, data} response carried through the read-latency pipeline.
package sram_pkg;

   localparam int unsigned SRAM_ADDR_W = 15;
   localparam int unsigned SRAM_DATA_W = 256;

   typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
   typedef logic [SRAM_DATA_W-1:0] sram_data_t;

   typedef struct packed {
      logic       valid;
      sram_data_t data;
   } sram_rsp_t;

endpackage

// File: rtl/sram_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one
// combinational read port sharing the same word index.
module sram_array #(
   parameter int unsigned DATA_W = 256,
   parameter int unsigned DEPTH  = 32768,
   parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx] <= wr_data;
      end
   end

   assign rd_data = mem[idx];

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder of the SRAM request interface: accepts qualified
// requests, serves reads after RD_LATENCY cycles, counts ops, flags OOB.
module sram_responder
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W     = SRAM_ADDR_W,
   parameter int unsigned DATA_W     = SRAM_DATA_W,
   parameter int unsigned DEPTH      = 32768,
   parameter int unsigned RD_LATENCY = 0,
   parameter int unsigned CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic              we,
   input  logic              valid_tx,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              err_oob,
   output logic [CNT_W-1:0]  wr_count,
   output logic [CNT_W-1:0]  rd_count
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic              in_range_c;
   logic              accept_wr_c;
   logic              accept_rd_c;
   logic              mem_we_c;
   logic [IDX_W-1:0]  idx_c;
   logic [DATA_W-1:0] mem_rd_c;
   logic [DATA_W-1:0] rd_data_c;

   // Accept decode and range check; an edge coinciding with rst writes nothing.
   assign in_range_c  = ({1'b0, addr} < DEPTH_L);
   assign accept_wr_c = valid_tx & we;
   assign accept_rd_c = valid_tx & ~we;
   assign mem_we_c    = accept_wr_c & in_range_c & ~rst;
   assign idx_c       = IDX_W'(addr);
   assign rd_data_c   = in_range_c ? mem_rd_c : '0;

   sram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (mem_we_c),
      .idx     (idx_c),
      .wr_data (din),
      .rd_data (mem_rd_c)
   );

   // Saturating operation counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         if (accept_wr_c && (wr_count != '1)) begin
            wr_count <= wr_count + CNT_W'(1);
         end
         if (accept_rd_c && (rd_count != '1)) begin
            rd_count <= rd_count + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_oob <= 1'b0;
      end else begin
         err_oob <= valid_tx & ~in_range_c;
      end
   end

   generate
      if (RD_LATENCY == 0) begin : g_comb
         // Driver samples dout at the posedge after setting addr at the negedge.
         assign dout       = (accept_rd_c && in_range_c) ? mem_rd_c : '0;
         assign dout_valid = accept_rd_c;
      end else begin : g_pipe
         sram_rsp_t pipe [RD_LATENCY];

         // Data only advances with its valid bit, so dout holds when idle.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int unsigned s = 0; s < RD_LATENCY; s++) begin
                  pipe[s] <= '0;
               end
            end else begin
               pipe[0].valid <= accept_rd_c;
               if (accept_rd_c) begin
                  pipe[0].data <= SRAM_DATA_W'(rd_data_c);
               end
               for (int unsigned s = 1; s < RD_LATENCY; s++) begin
                  pipe[s].valid <= pipe[s-1].valid;
                  if (pipe[s-1].valid) begin
                     pipe[s].data <= pipe[s-1].data;
                  end
               end
            end
         end

         assign dout       = DATA_W'(pipe[RD_LATENCY-1].data);
         assign dout_valid = pipe[RD_LATENCY-1].valid;
      end
   endgenerate

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench: four responders (latency 0..3) driven independently,
// checked with immediate assertions against hand-computed values.
module tb_sram_responder;

   logic clk = 1'b0;
   logic rst;

   logic [14:0]  addr     [4];
   logic [255:0] din      [4];
   logic         we       [4];
   logic         valid_tx [4];

   logic [255:0] dout0, dout1, dout2, dout3;
   logic         dv0, dv1, dv2, dv3;
   logic         err0, err1, err2, err3;
   logic [31:0]  wrc0, wrc1, wrc2, rdc0, rdc1, rdc2;
   logic [3:0]   wrc3, rdc3;

   int nvec = 0;
   int nerr = 0;

   localparam logic [255:0] PAT_A5 = {32{8'hA5}};

   always #5 clk = ~clk;

   sram_responder #(.RD_LATENCY(0)) u0 (
      .clk(clk), .rst(rst), .addr(addr[0]), .din(din[0]), .we(we[0]),
      .valid_tx(valid_tx[0]), .dout(dout0), .dout_valid(dv0), .err_oob(err0),
      .wr_count(wrc0), .rd_count(rdc0));

   sram_responder #(.DEPTH(1024), .RD_LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .addr(addr[1]), .din(din[1]), .we(we[1]),
      .valid_tx(valid_tx[1]), .dout(dout1), .dout_valid(dv1), .err_oob(err1),
      .wr_count(wrc1), .rd_count(rdc1));

   sram_responder #(.DEPTH(1024), .RD_LATENCY(2)) u2 (
      .clk(clk), .rst(rst), .addr(addr[2]), .din(din[2]), .we(we[2]),
      .valid_tx(valid_tx[2]), .dout(dout2), .dout_valid(dv2), .err_oob(err2),
      .wr_count(wrc2), .rd_count(rdc2));

   sram_responder #(.DEPTH(1024), .RD_LATENCY(3), .CNT_W(4)) u3 (
      .clk(clk), .rst(rst), .addr(addr[3]), .din(din[3]), .we(we[3]),
      .valid_tx(valid_tx[3]), .dout(dout3), .dout_valid(dv3), .err_oob(err3),
      .wr_count(wrc3), .rd_count(rdc3));

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req(input int i, input logic w, input logic [14:0] a, input logic [255:0] d);
      @(negedge clk);
      valid_tx[i] = 1'b1;
      we[i]       = w;
      addr[i]     = a;
      din[i]      = d;
   endtask

   task automatic idle(input int i);
      @(negedge clk);
      valid_tx[i] = 1'b0;
      we[i]       = 1'bx;
      addr[i]     = 'x;
      din[i]      = 'x;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         valid_tx[i] = 1'b0;
         we[i]       = 1'b0;
         addr[i]     = '0;
         din[i]      = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout1", dout1, 256'(0));
      chk("rst_dv2", 256'(dv2), 256'(0));
      chk("rst_err3", 256'(err3), 256'(0));
      chk("rst_wrc0", 256'(wrc0), 256'(0));
      chk("rst_rdc3", 256'(rdc3), 256'(0));
      chk("rst_dout3", dout3, 256'(0));
      @(negedge clk);
      rst = 1'b0;

      // Latency 0: write then combinational read
      req(0, 1'b1, 15'h1234, PAT_A5);
      tick();
      chk("l0_wrc", 256'(wrc0), 256'(1));
      chk("l0_dv_on_write", 256'(dv0), 256'(0));
      req(0, 1'b0, 15'h1234, '0);
      #1;
      chk("l0_dout", dout0, PAT_A5);
      chk("l0_dv", 256'(dv0), 256'(1));
      chk("l0_rdc_before", 256'(rdc0), 256'(0));
      tick();
      chk("l0_rdc", 256'(rdc0), 256'(1));
      idle(0);
      #1;
      chk("l0_idle_dv", 256'(dv0), 256'(0));
      chk("l0_idle_dout", dout0, 256'(0));

      // Latency 2: preload then three back-to-back reads
      req(2, 1'b1, 15'd0, 256'h10);
      req(2, 1'b1, 15'd1, 256'h11);
      req(2, 1'b1, 15'd2, 256'h12);
      req(2, 1'b0, 15'd0, '0);
      tick();
      chk("l2_r0_dv", 256'(dv2), 256'(0));
      req(2, 1'b0, 15'd1, '0);
      tick();
      chk("l2_out0_dv", 256'(dv2), 256'(1));
      chk("l2_out0", dout2, 256'h10);
      req(2, 1'b0, 15'd2, '0);
      tick();
      chk("l2_out1_dv", 256'(dv2), 256'(1));
      chk("l2_out1", dout2, 256'h11);
      idle(2);
      tick();
      chk("l2_out2_dv", 256'(dv2), 256'(1));
      chk("l2_out2", dout2, 256'h12);
      tick();
      chk("l2_after_dv", 256'(dv2), 256'(0));
      chk("l2_hold", dout2, 256'h12);
      chk("l2_wrc", 256'(wrc2), 256'(3));
      chk("l2_rdc", 256'(rdc2), 256'(3));

      // Latency 1: read-then-write and write-then-read hazards
      req(1, 1'b1, 15'h5, 256'h0);
      req(1, 1'b0, 15'h5, '0);
      tick();
      chk("l1_rd5_dv", 256'(dv1), 256'(1));
      chk("l1_rd5_old", dout1, 256'h0);
      req(1, 1'b1, 15'h5, 256'hFF);
      tick();
      chk("l1_wr_dv", 256'(dv1), 256'(0));
      chk("l1_hold", dout1, 256'h0);
      req(1, 1'b0, 15'h5, '0);
      tick();
      chk("l1_rd5_new", dout1, 256'hFF);
      req(1, 1'b1, 15'h6, 256'h77);
      req(1, 1'b0, 15'h6, '0);
      tick();
      chk("l1_rd6_dv", 256'(dv1), 256'(1));
      chk("l1_rd6", dout1, 256'h77);

      // Out-of-range on DEPTH=1024
      req(1, 1'b1, 15'h3FF, 256'h55);
      req(1, 1'b1, 15'h7FFF, 256'hDEAD);
      tick();
      chk("oob_wr_err", 256'(err1), 256'(1));
      idle(1);
      tick();
      chk("oob_err_clear", 256'(err1), 256'(0));
      req(1, 1'b0, 15'h3FF, '0);
      tick();
      chk("oob_mem_intact", dout1, 256'h55);
      chk("oob_inrange_err", 256'(err1), 256'(0));
      req(1, 1'b0, 15'h7FFF, '0);
      tick();
      chk("oob_rd_dout", dout1, 256'(0));
      chk("oob_rd_dv", 256'(dv1), 256'(1));
      chk("oob_rd_err", 256'(err1), 256'(1));
      idle(1);
      tick();
      chk("oob_rd_err_clear", 256'(err1), 256'(0));
      chk("oob_dv_clear", 256'(dv1), 256'(0));
      chk("l1_wrc", 256'(wrc1), 256'(5));
      chk("l1_rdc", 256'(rdc1), 256'(5));

      // CNT_W=4 saturation
      for (int n = 0; n < 20; n++) begin
         req(3, 1'b1, 15'(n), 256'(n));
         tick();
         chk($sformatf("sat_wrc_%0d", n), 256'(wrc3), 256'((n + 1 > 15) ? 15 : n + 1));
      end

      // Latency 3: reset while a read is in flight
      req(3, 1'b1, 15'h20, 256'hBEEF);
      req(3, 1'b0, 15'h20, '0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      valid_tx[3] = 1'b0;
      #1;
      chk("rst_mid_dout", dout3, 256'(0));
      chk("rst_mid_dv", 256'(dv3), 256'(0));
      chk("rst_mid_err", 256'(err3), 256'(0));
      chk("rst_mid_wrc", 256'(wrc3), 256'(0));
      chk("rst_mid_rdc", 256'(rdc3), 256'(0));
      chk("rst_mid_wrc1", 256'(wrc1), 256'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk($sformatf("rst_no_dv_%0d", n), 256'(dv3), 256'(0));
      end
      req(3, 1'b0, 15'h20, '0);
      tick();
      chk("l3_k0_dv", 256'(dv3), 256'(0));
      idle(3);
      tick();
      chk("l3_k1_dv", 256'(dv3), 256'(0));
      tick();
      chk("l3_k2_dv", 256'(dv3), 256'(1));
      chk("l3_data_kept", dout3, 256'hBEEF);
      chk("l3_rdc", 256'(rdc3), 256'(1));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
